// File: rtl/wave_gen_pkg.sv
// Shared definitions for the phase-accumulator waveform generator.
package wave_gen_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO     = 2'b00,
        MODE_SQUARE   = 2'b01,
        MODE_TRIANGLE = 2'b10,
        MODE_SAWTOOTH = 2'b11
    } mode_t;

endpackage

// File: rtl/wave_shape.sv
// Combinational index-to-sample shaper: zero, square, triangle or sawtooth.
module wave_shape
    import wave_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  mode_t          mode,
    input  logic [W-1:0]   index,
    input  logic [W-1:0]   duty,
    output logic [W-1:0]   sample
);

    logic [W-1:0] ramp;

    // Doubled index drives both slopes; the falling half is its bitwise complement.
    assign ramp = {index[W-2:0], 1'b0};

    // Select the waveform for the current index.
    always_comb begin
        sample = '0;
        unique case (mode)
            MODE_ZERO:     sample = '0;
            MODE_SQUARE:   sample = (index < duty) ? '1 : '0;
            MODE_TRIANGLE: sample = index[W-1] ? ~ramp : ramp;
            MODE_SAWTOOTH: sample = index;
            default:       sample = '0;
        endcase
    end

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator with double-buffered configuration
// that is applied only at a period boundary (or while idle).
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned PHASE_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               load,
    input  logic [1:0]         mode_in,
    input  logic [PHASE_W-1:0] freq_in,
    input  logic [W-1:0]       duty_in,
    output logic [W-1:0]       value,
    output logic               wrap,
    output logic               pending
);

    localparam logic [W-1:0] DUTY_RST = {1'b1, {(W-1){1'b0}}};

    logic [PHASE_W-1:0] phase_q;
    logic [W-1:0]       value_q;
    logic               wrap_q;
    logic               pending_q;

    mode_t              mode_act_q, mode_sh_q;
    logic [PHASE_W-1:0] freq_act_q, freq_sh_q;
    logic [W-1:0]       duty_act_q, duty_sh_q;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               apply_evt;
    logic [W-1:0]       sample;

    assign sum   = {1'b0, phase_q} + {1'b0, freq_act_q};
    assign carry = sum[PHASE_W];

    // A stalled or zero-rate accumulator never wraps, so apply immediately there.
    assign apply_evt = (pending_q | load) &
                       ((enable & carry) | ~enable | (freq_act_q == '0));

    wave_shape #(
        .W (W)
    ) u_shape (
        .mode   (mode_act_q),
        .index  (phase_q[PHASE_W-1 -: W]),
        .duty   (duty_act_q),
        .sample (sample)
    );

    // Accumulator and registered outputs advance only while enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else if (enable) begin
            phase_q <= sum[PHASE_W-1:0];
            wrap_q  <= carry;
            value_q <= sample;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    // Shadow capture on load; active update on an apply event, bypassing the
    // shadow when a load lands in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_sh_q  <= MODE_ZERO;
            freq_sh_q  <= '0;
            duty_sh_q  <= DUTY_RST;
            mode_act_q <= MODE_ZERO;
            freq_act_q <= '0;
            duty_act_q <= DUTY_RST;
            pending_q  <= 1'b0;
        end else begin
            if (load) begin
                mode_sh_q <= mode_t'(mode_in);
                freq_sh_q <= freq_in;
                duty_sh_q <= duty_in;
            end
            if (apply_evt) begin
                mode_act_q <= load ? mode_t'(mode_in) : mode_sh_q;
                freq_act_q <= load ? freq_in : freq_sh_q;
                duty_act_q <= load ? duty_in : duty_sh_q;
                pending_q  <= 1'b0;
            end else if (load) begin
                pending_q  <= 1'b1;
            end
        end
    end

    assign value   = value_q;
    assign wrap    = wrap_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen (W=8, PHASE_W=16) against a behavioural model.
module tb_wave_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [15:0] freq_in = 16'd0;
    logic [7:0]  duty_in = 8'd0;
    logic [7:0]  value;
    logic        wrap;
    logic        pending;

    wave_gen #(
        .W       (8),
        .PHASE_W (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .load    (load),
        .mode_in (mode_in),
        .freq_in (freq_in),
        .duty_in (duty_in),
        .value   (value),
        .wrap    (wrap),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (plain integers).
    int m_phase, m_value, m_wrap, m_pend;
    int a_mode, a_freq, a_duty;
    int s_mode, s_freq, s_duty;

    function automatic int ref_shape(int md, int idx, int dt);
        case (md)
            0:       return 0;
            1:       return (idx < dt) ? 255 : 0;
            2:       return (idx < 128) ? 2 * idx : 255 - 2 * (idx - 128);
            default: return idx;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_value = 0; m_wrap = 0; m_pend = 0;
        a_mode = 0; a_freq = 0; a_duty = 128;
        s_mode = 0; s_freq = 0; s_duty = 128;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".value"}, {8'h00, value}, 16'(m_value));
        check({tag, ".wrap"}, {15'h0, wrap}, 16'(m_wrap));
        check({tag, ".pending"}, {15'h0, pending}, 16'(m_pend));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input bit en, input bit ld, input int md, input int fr, input int dt);
        int  sum, n_phase, n_value, n_wrap, n_pend;
        bit  carry, apply;
        enable = en; load = ld; mode_in = 2'(md); freq_in = 16'(fr); duty_in = 8'(dt);
        sum   = m_phase + a_freq;
        carry = en && (sum >= 65536);
        apply = (m_pend != 0 || ld) && ((en && carry) || !en || a_freq == 0);
        n_phase = en ? sum % 65536 : m_phase;
        n_value = en ? ref_shape(a_mode, m_phase / 256, a_duty) : m_value;
        n_wrap  = en ? int'(carry) : 0;
        n_pend  = apply ? 0 : (ld ? 1 : m_pend);
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            if (apply) begin
                a_mode = ld ? md : s_mode;
                a_freq = ld ? fr : s_freq;
                a_duty = ld ? dt : s_duty;
            end
            if (ld) begin
                s_mode = md; s_freq = fr; s_duty = dt;
            end
            m_phase = n_phase; m_value = n_value; m_wrap = n_wrap; m_pend = n_pend;
        end
        check_outputs("step");
    endtask

    // Enabled or disabled cycles with random *_in noise and no load.
    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++)
            step(en, 1'b0, $urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 255));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int fr;
        model_reset();

        // Reset held with random inputs, then mode zero after release.
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 65535), $urandom_range(0, 255));
        reset_n = 1'b1;
        run(4, 1'b1);
        check("reset_zero", {8'h00, value}, 16'h0000);

        // Sawtooth: load while disabled, then 256 enabled cycles hold exactly one wrap.
        step(1'b0, 1'b1, 3, 16'h0100, 0);
        step(1'b0, 1'b0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            if (wrap) cnt++;
        end
        check("saw_wrap_count", 16'(cnt), 16'd1);
        run(4, 1'b1);

        // Triangle full period.
        step(1'b0, 1'b1, 2, 16'h0100, 0);
        run(260, 1'b1);

        // Square duty 0x40: 64 high samples per period; duty 0: none.
        step(1'b0, 1'b1, 1, 16'h0100, 8'h40);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            if (value == 8'hFF) cnt++;
        end
        check("square_high_count", 16'(cnt), 16'd64);
        step(1'b0, 1'b1, 1, 16'h0100, 8'h00);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 0, 0, 0);
            if (value != 8'h00) cnt++;
        end
        check("square_duty0_count", 16'(cnt), 16'd0);

        // Deferred load: sawtooth running, load triangle at index 0x30.
        step(1'b0, 1'b1, 3, 16'h0100, 0);
        for (int i = 0; i < 300 && (m_phase / 256) != 8'h30; i++) step(1'b1, 1'b0, 0, 0, 0);
        check("reach_idx30", 16'(m_phase / 256), 16'h0030);
        step(1'b1, 1'b1, 2, 16'h0100, 0);
        check("deferred_pending", {15'h0, pending}, 16'h0001);
        run(300, 1'b1);

        // Double load before wrap: only the second one is applied.
        run(20, 1'b1);
        step(1'b1, 1'b1, 1, 16'h0100, 8'h80);
        run(5, 1'b1);
        step(1'b1, 1'b1, 3, 16'h0200, 8'h10);
        run(300, 1'b1);

        // Async reset mid-period with a load pending.
        run(30, 1'b1);
        step(1'b1, 1'b1, 1, 16'h0300, 8'h20);
        check("pre_reset_pending", {15'h0, pending}, 16'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        run(2, 1'b1);
        reset_n = 1'b1;
        run(20, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 3))
                0:       fr = 0;
                1:       fr = 16'h8000;
                2:       fr = $urandom_range(1, 1024);
                default: fr = $urandom_range(0, 65535);
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3), fr, $urandom_range(0, 255));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
